// File: rtl/dsp_addsub_arbiter.sv
// rtl/dsp_addsub_arbiter.sv - two-port arbiter sharing one 32-bit add/sub DSP tile; DSP_ADDSUB_ROUND_ROBIN_EN selects round-robin contention
module dsp_addsub_arbiter #(
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0,
    input  logic                       req1,
    input  logic                       sub0,
    input  logic                       sub1,
    input  logic [31:0]                a0,
    input  logic [31:0]                b0,
    input  logic [31:0]                a1,
    input  logic [31:0]                b1,
    output logic                       gnt0,
    output logic                       gnt1,
    output logic                       done0,
    output logic                       done1,
    output logic [31:0]                result,
    output logic                       co,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

    logic                       r_done0;
    logic                       r_done1;
    logic [31:0]                r_result;
    logic                       r_co;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_pick1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_stall;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_sub;
    logic [31:0] w_b_op;
    logic [32:0] w_sum;

    // A port whose done is showing this cycle is masked so a held request is not reissued
    assign w_elig0 = req0 & ~r_done0;
    assign w_elig1 = req1 & ~r_done1;

`ifdef DSP_ADDSUB_ROUND_ROBIN_EN
    logic r_last;

    // Remember the most recently granted port; reset to 1 so port 0 wins the first contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end

    assign w_pick1 = ~r_last;
`else
    // Fixed priority: port 0 always wins contention
    assign w_pick1 = 1'b0;
`endif

    assign w_gnt0 = ~reset & w_elig0 & (~w_elig1 | ~w_pick1);
    assign w_gnt1 = ~reset & w_elig1 & (~w_elig0 |  w_pick1);
    assign w_stall = (w_elig0 & ~w_gnt0) | (w_elig1 & ~w_gnt1);

    // Shared adder: subtract is a + ~b + 1, so the carry-out is the no-borrow flag (a >= b)
    assign w_a    = w_gnt1 ? a1   : a0;
    assign w_b    = w_gnt1 ? b1   : b0;
    assign w_sub  = w_gnt1 ? sub1 : sub0;
    assign w_b_op = w_sub ? ~w_b : w_b;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b_op} + {32'b0, w_sub};

    // Capture the result on a grant and pulse the granted port's done for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= 32'b0;
            r_co     <= 1'b0;
        end else begin
            r_done0 <= w_gnt0;
            r_done1 <= w_gnt1;
            if (w_gnt0 | w_gnt1) begin
                r_result <= w_sum[31:0];
                r_co     <= w_sum[32];
            end
        end
    end

    // Saturating count of cycles where an eligible port went ungranted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign result    = r_result;
    assign co        = r_co;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// tb/tb_dsp_addsub_arbiter.sv - model-checked random and directed bench for dsp_addsub_arbiter
module tb_dsp_addsub_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, sub0, sub1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, co;
    logic [31:0] result;
    logic [15:0] stall_cnt;
    logic        gnt0_4, gnt1_4, done0_4, done1_4, co_4;
    logic [31:0] result_4;
    logic [3:0]  stall_cnt_4;

    int errors = 0;
    int checks = 0;

    // behavioural model state: what the registered outputs must show this cycle
    logic [1:0]  m_done;
    logic [31:0] m_result;
    logic        m_co;
    int          m_stall;
    int          m_last;

    // requester bookkeeping for random phase
    bit          pend0, pend1;
    bit          rand_phase;

    dsp_addsub_arbiter #(.STALL_CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .co(co), .stall_cnt(stall_cnt)
    );

    dsp_addsub_arbiter #(.STALL_CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_4), .gnt1(gnt1_4), .done0(done0_4), .done1(done1_4),
        .result(result_4), .co(co_4), .stall_cnt(stall_cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Reference model + per-cycle comparison of both instances
    always @(negedge clk) begin
        bit e0, e1, g0, g1;
        logic [63:0] ea, eb, sum;
        int s16, s4;
        s16 = (m_stall > 65535) ? 65535 : m_stall;
        s4  = (m_stall > 15) ? 15 : m_stall;
        if (reset) begin
            m_done = 2'b00; m_result = 32'h0; m_co = 1'b0; m_stall = 0; m_last = 1;
            check("rst_gnt", {gnt1, gnt0, gnt1_4, gnt0_4}, 4'h0);
            check("rst_done", {done1, done0, done1_4, done0_4}, 4'h0);
            check("rst_result", {result, result_4}, 64'h0);
            check("rst_co_stall", {co, co_4, stall_cnt, stall_cnt_4}, 22'h0);
        end else begin
            e0 = req0 && !m_done[0];
            e1 = req1 && !m_done[1];
            if (e0 && e1) begin
`ifdef DSP_ADDSUB_ROUND_ROBIN_EN
                g1 = (m_last == 0);
`else
                g1 = 1'b0;
`endif
                g0 = !g1;
            end else begin
                g0 = e0;
                g1 = e1;
            end
            check("gnt", {gnt1, gnt0}, {g1, g0});
            check("gnt_w4", {gnt1_4, gnt0_4}, {g1, g0});
            check("done", {done1, done0, done1_4, done0_4}, {m_done, m_done});
            check("result", result, m_result);
            check("result_w4", result_4, m_result);
            check("co", {co, co_4}, {m_co, m_co});
            check("stall16", stall_cnt, s16);
            check("stall4", stall_cnt_4, s4);
            if (g0 || g1) begin
                ea = g1 ? a1 : a0;
                eb = g1 ? b1 : b0;
                if (g1 ? sub1 : sub0) begin
                    m_result = 32'((ea - eb) & 64'hFFFF_FFFF);
                    m_co     = (ea >= eb);
                end else begin
                    sum      = ea + eb;
                    m_result = sum[31:0];
                    m_co     = sum[32];
                end
                m_last = g1 ? 1 : 0;
            end
            m_done = {g1, g0};
            if ((e0 && !g0) || (e1 && !g1)) m_stall++;
        end
    end

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        pend0 = 0; pend1 = 0; rand_phase = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // single add
        req0 = 1; a0 = 32'h5; b0 = 32'h3; sub0 = 0;
        mid();
        check("lit_add_gnt", {gnt1, gnt0}, 2'b01);
        next_cycle();
        mid();
        check("lit_add_done", {done1, done0}, 2'b01);
        check("lit_add_result", {co, result}, {1'b0, 32'h0000_0008});
        check("lit_add_masked", gnt0, 1'b0);
        next_cycle();
        req0 = 0;
        mid();
        check("lit_add_nodone2", done0, 1'b0);

        // wrap on port 1
        next_cycle();
        req1 = 1; a1 = 32'hFFFF_FFFF; b1 = 32'h1; sub1 = 0;
        mid();
        check("lit_wrap_gnt", {gnt1, gnt0}, 2'b10);
        next_cycle();
        req1 = 0;
        mid();
        check("lit_wrap_result", {done1, co, result}, {1'b1, 1'b1, 32'h0});

        // subtract with borrow
        next_cycle();
        req0 = 1; a0 = 32'h3; b0 = 32'h5; sub0 = 1;
        next_cycle();
        req0 = 0;
        mid();
        check("lit_borrow_result", {done0, co, result}, {1'b1, 1'b0, 32'hFFFF_FFFE});

        // contention right after reset
        next_cycle();
        reset = 1;
        next_cycle();
        reset = 0;
        req0 = 1; a0 = 32'd10; b0 = 32'd1; sub0 = 0;
        req1 = 1; a1 = 32'd7;  b1 = 32'd2; sub1 = 1;
        mid();
        check("lit_cont_gnt_first", {gnt1, gnt0}, 2'b01);
        next_cycle();
        mid();
        check("lit_cont_second", {gnt1, done0, result}, {1'b1, 1'b1, 32'd11});
        check("lit_cont_stall", stall_cnt, 16'd1);
        next_cycle();
        req0 = 0;
        mid();
        check("lit_cont_done1", {done1, co, result}, {1'b1, 1'b1, 32'd5});
        next_cycle();
        req1 = 0;

        // both held continuously: alternating grants, done every cycle
        next_cycle();
        req0 = 1; req1 = 1;
        for (int k = 0; k < 8; k++) begin
            mid();
            check("lit_alt_gnt", {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) check("lit_alt_done", {done1, done0}, (k % 2 == 1) ? 2'b01 : 2'b10);
            next_cycle();
        end
        req0 = 0; req1 = 0;
        next_cycle();

        // reset in the cycle after a grant
        req0 = 1; a0 = 32'd100; b0 = 32'd23; sub0 = 0;
        mid();
        check("lit_rst_gnt", gnt0, 1'b1);
        next_cycle();
        reset = 1;
        #1;
        check("lit_rst_clear", {gnt0, done0, result, stall_cnt}, 50'h0);
        next_cycle();
        reset = 0;
        mid();
        check("lit_rst_regrant", gnt0, 1'b1);
        next_cycle();
        mid();
        check("lit_rst_complete", {done0, result}, {1'b1, 32'd123});
        next_cycle();
        req0 = 0;
        next_cycle();

        // repeated fresh contention: port 1 never completes, counter saturates in the narrow instance
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin
                req0 = 1; a0 = $urandom; b0 = $urandom; sub0 = 1'($urandom);
                req1 = 1; a1 = $urandom; b1 = $urandom; sub1 = 1'($urandom);
            end else begin
                req0 = 0; req1 = 0;
            end
            next_cycle();
        end
        req0 = 0; req1 = 0;
        mid();
        check("lit_sat_w4", stall_cnt_4, 4'hF);
        check("lit_sat_w16", stall_cnt, 16'd20);
        next_cycle();

        // random traffic under protocol, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (m_done[0] && !reset) begin
                pend0 = 0;
                req0 = 1'($urandom);
            end else if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1; req0 = 1;
                a0 = rnd_operand(); b0 = ($urandom_range(0, 7) == 0) ? a0 : rnd_operand();
                sub0 = 1'($urandom);
            end else if (!pend0) begin
                req0 = 0;
            end
            if (m_done[1] && !reset) begin
                pend1 = 0;
                req1 = 1'($urandom);
            end else if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1; req1 = 1;
                a1 = rnd_operand(); b1 = ($urandom_range(0, 7) == 0) ? a1 : rnd_operand();
                sub1 = 1'($urandom);
            end else if (!pend1) begin
                req1 = 0;
            end
            next_cycle();
        end
        reset = 0; req0 = 0; req1 = 0;
        repeat (2) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
